// File: rtl/serial_pattern_tx_if.sv
// Load/serial-output bundle for serial_pattern_tx.
// The master drives the load port and the slave (the transmitter) drives the serial outputs.
interface serial_pattern_tx_if #(
   parameter int W     = 4,
   parameter int CNT_W = 4
) ();
   logic             load_valid;
   logic             load_ready;
   logic [W-1:0]     pattern;
   logic [CNT_W-1:0] repeat_cnt;
   logic             x;
   logic             x_valid;
   logic             frame_start;
   logic             done;

   modport master (
      output load_valid, pattern, repeat_cnt,
      input  load_ready, x, x_valid, frame_start, done
   );

   modport slave (
      input  load_valid, pattern, repeat_cnt,
      output load_ready, x, x_valid, frame_start, done
   );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: emits a loaded W-bit pattern MSB-first (repeat+1) times.
// Optional feature macro PARITY_TX_EN appends an even-parity bit to every frame.
module serial_pattern_tx #(
   parameter int W     = 4,
   parameter int CNT_W = 4,
   parameter int GAP   = 1
) (
   input  logic               clk,
   input  logic               reset,
   serial_pattern_tx_if.slave bus_if
);
   localparam int                IDX_W    = (W > 1) ? $clog2(W) : 1;
   localparam logic [IDX_W-1:0]  MSB_IDX  = IDX_W'(W - 1);
   localparam logic [3:0]        GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef PARITY_TX_EN
   typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;
`endif

   state_t             state_q, state_d;
   logic [W-1:0]       shreg_q, shreg_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   rep_q, rep_d;
   logic [3:0]         gap_q, gap_d;

   logic x_o, x_valid_o, frame_start_o, done_o, load_ready_o;
   logic capture, eof;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      idx_d         = idx_q;
      rep_d         = rep_q;
      gap_d         = gap_q;
      x_o           = 1'b0;
      x_valid_o     = 1'b0;
      frame_start_o = 1'b0;
      done_o        = 1'b0;
      load_ready_o  = 1'b0;
      capture       = 1'b0;
      eof           = 1'b0;

      case (state_q)
         S_IDLE: begin
            load_ready_o = 1'b1;
            capture      = bus_if.load_valid;
         end
         S_SHIFT: begin
            x_valid_o     = 1'b1;
            x_o           = shreg_q[idx_q];
            frame_start_o = (idx_q == MSB_IDX);
            if (idx_q == '0) begin
`ifdef PARITY_TX_EN
               state_d = S_PAR;
`else
               eof     = 1'b1;
`endif
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
`ifdef PARITY_TX_EN
         S_PAR: begin
            x_valid_o = 1'b1;
            x_o       = ^shreg_q;
            eof       = 1'b1;
         end
`endif
         S_GAP: begin
            if (gap_q == '0) state_d = S_SHIFT;
            else             gap_d   = gap_q - 1'b1;
         end
         S_DONE: begin
            done_o       = 1'b1;
            load_ready_o = 1'b1;
            capture      = bus_if.load_valid;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // rep counts frames still owed after the current one, so it stops at zero
      if (eof) begin
         if (rep_q == '0) begin
            state_d = S_DONE;
         end else begin
            rep_d   = rep_q - 1'b1;
            idx_d   = MSB_IDX;
            gap_d   = GAP_LAST;
            state_d = (GAP > 0) ? S_GAP : S_SHIFT;
         end
      end

      if (capture) begin
         shreg_d = bus_if.pattern;
         rep_d   = bus_if.repeat_cnt;
         idx_d   = MSB_IDX;
         state_d = S_SHIFT;
      end
   end

   assign bus_if.x           = x_o;
   assign bus_if.x_valid     = x_valid_o;
   assign bus_if.frame_start = frame_start_o;
   assign bus_if.done        = done_o;
   assign bus_if.load_ready  = load_ready_o;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: each accepted load expands into its expected
// per-cycle output trace; a monitor pops one entry per cycle and compares.
module tb_serial_pattern_tx;
   localparam int W     = 4;
   localparam int CNT_W = 4;
   localparam int GAP   = 1;
`ifdef PARITY_TX_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   typedef struct {
      bit x;
      bit v;
      bit fs;
      bit dn;
      bit rdy;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   bit   exp_rdy = 1'b1;
   ent_t exp_q[$];

   serial_pattern_tx_if #(.W(W), .CNT_W(CNT_W)) ifc ();

   serial_pattern_tx #(.W(W), .CNT_W(CNT_W), .GAP(GAP)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_if (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Expected trace of one load: frames of MSB-first bits, gaps between frames, then DONE.
   task automatic push_load(input logic [W-1:0] pat, input logic [CNT_W-1:0] rep);
      for (int f = 0; f <= int'(rep); f++) begin
         for (int b = W - 1; b >= 0; b--)
            exp_q.push_back('{x: pat[b], v: 1'b1, fs: (b == W - 1), dn: 1'b0, rdy: 1'b0});
         if (P == 1)
            exp_q.push_back('{x: ^pat, v: 1'b1, fs: 1'b0, dn: 1'b0, rdy: 1'b0});
         if (f < int'(rep))
            for (int g = 0; g < GAP; g++)
               exp_q.push_back('{x: 1'b0, v: 1'b0, fs: 1'b0, dn: 1'b0, rdy: 1'b0});
      end
      exp_q.push_back('{x: 1'b0, v: 1'b0, fs: 1'b0, dn: 1'b1, rdy: 1'b1});
   endtask

   task automatic drive(input bit lv, input logic [W-1:0] p, input logic [CNT_W-1:0] r);
      @(negedge clk);
      ifc.load_valid = lv;
      ifc.pattern    = p;
      ifc.repeat_cnt = r;
      if (lv && exp_rdy) push_load(p, r);
   endtask

   // Monitor: outputs of the cycle just started by the rising edge
   always begin
      ent_t e;
      @(posedge clk);
      #1;
      if (!reset) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = '{x: 1'b0, v: 1'b0, fs: 1'b0, dn: 1'b0, rdy: 1'b1};
         chk("x",           ifc.x,           e.x);
         chk("x_valid",     ifc.x_valid,     e.v);
         chk("frame_start", ifc.frame_start, e.fs);
         chk("done",        ifc.done,        e.dn);
         chk("load_ready",  ifc.load_ready,  e.rdy);
         exp_rdy = e.rdy;
      end
   end

   initial begin
      int guard;
      reset          = 1'b1;
      ifc.load_valid = 1'b0;
      ifc.pattern    = '0;
      ifc.repeat_cnt = '0;
      #1;
      chk("rst_x",           ifc.x,           1'b0);
      chk("rst_x_valid",     ifc.x_valid,     1'b0);
      chk("rst_frame_start", ifc.frame_start, 1'b0);
      chk("rst_done",        ifc.done,        1'b0);
      chk("rst_load_ready",  ifc.load_ready,  1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // single frame, then three frames with gaps
      drive(1'b1, 4'b1011, 4'd0);
      repeat (8) drive(1'b0, 4'b0000, 4'd0);
      drive(1'b1, 4'b1011, 4'd2);
      repeat (20) drive(1'b0, 4'b0000, 4'd0);

      // held load while busy is ignored; it is taken in the DONE cycle
      drive(1'b1, 4'b1001, 4'd1);
      repeat (12) drive(1'b1, 4'b0110, 4'd0);
      repeat (10) drive(1'b0, 4'b0000, 4'd0);

      // reset during the second bit aborts the frame with no done pulse
      drive(1'b1, 4'b1100, 4'd3);
      drive(1'b0, 4'b0000, 4'd0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("abort_x",          ifc.x,          1'b0);
      chk("abort_x_valid",    ifc.x_valid,    1'b0);
      chk("abort_done",       ifc.done,       1'b0);
      chk("abort_load_ready", ifc.load_ready, 1'b1);
      exp_q.delete();
      exp_rdy = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (6) drive(1'b0, 4'b0000, 4'd0);

      // maximum repeat count
      drive(1'b1, 4'b0111, 4'hF);
      repeat (5) drive(1'b0, 4'b0000, 4'd0);

      // randomized loads with garbage on the bus while busy
      for (int i = 0; i < 600; i++) begin
         logic [CNT_W-1:0] r;
         r = ($urandom % 10 == 0) ? CNT_W'($urandom) : CNT_W'($urandom % 3);
         drive(($urandom % 3) == 0, W'($urandom), r);
      end
      drive(1'b0, 4'b0000, 4'd0);

      guard = 0;
      while (exp_q.size() > 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
